// File: rtl/ws_loop_ctrl.sv
// ws_loop_ctrl: weight-stationary loader and triple-nested loop sequencer for a PE array
module ws_loop_ctrl #(
    parameter int OP_WIDTH   = 8,
    parameter int CTRL_WIDTH = 9,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  nw,
    input  logic [CNT_WIDTH-1:0]  tn,
    input  logic [CNT_WIDTH-1:0]  tk,
    input  logic [CNT_WIDTH-1:0]  tm,
    input  logic                  w_valid,
    input  logic [OP_WIDTH-1:0]   w_data,
    output logic                  w_ready,
    input  logic                  stall,
    output logic                  wctrl,
    output logic [OP_WIDTH-1:0]   weight,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state;
    logic [CNT_WIDTH-1:0] nw_r, tn_r, tk_r, tm_r, wcnt, n, k, m;
    logic last_n, last_k, last_m;
    logic [CTRL_WIDTH-1:0] word;
    assign last_n = n == tn_r - 1'b1;
    assign last_k = k == tk_r - 1'b1;
    assign last_m = m == tm_r - 1'b1;
    // control word for the current loop position; row/column/final markers are exclusive
    always_comb begin
        word    = '0;
        word[0] = 1'b1;
        word[7] = last_n && !last_k;
        word[5] = last_n && last_k && !last_m;
        word[3] = last_n && last_k && last_m;
    end
    // sequencer: state, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            {nw_r, tn_r, tk_r, tm_r} <= '0;
            {wcnt, n, k, m} <= '0;
            ctrl    <= '0;
            wctrl   <= 1'b0;
            weight  <= '0;
            w_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wctrl <= w_valid && w_ready;
            if (w_valid && w_ready) weight <= w_data;
            ctrl <= '0;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    nw_r <= nw;
                    tn_r <= tn;
                    tk_r <= tk;
                    tm_r <= tm;
                    if (tn == '0 || tk == '0 || tm == '0) state <= DONE;
                    else begin
                        state   <= (nw != '0) ? LOAD : RUN;
                        w_ready <= nw != '0;
                        busy    <= 1'b1;
                    end
                end
                LOAD: if (w_valid) begin
                    if (wcnt == nw_r - 1'b1) begin
                        wcnt    <= '0;
                        state   <= RUN;
                        w_ready <= 1'b0;
                    end else wcnt <= wcnt + 1'b1;
                end
                RUN: if (!stall) begin
                    ctrl <= word;
                    if (!last_n) n <= n + 1'b1;
                    else begin
                        n <= '0;
                        if (!last_k) k <= k + 1'b1;
                        else begin
                            k <= '0;
                            if (!last_m) m <= m + 1'b1;
                            else begin
                                m     <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ws_loop_ctrl.sv
// tb_ws_loop_ctrl: scoreboard bench for the weight loader and loop sequencer
module tb_ws_loop_ctrl;
    logic       clk, rst, start, w_valid, stall;
    logic [9:0] nw, tn, tk, tm;
    logic [7:0] w_data;
    logic       w_ready, wctrl, busy, done;
    logic [7:0] weight;
    logic [8:0] ctrl;
    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, fin_cyc = 0, wc_cnt = 0;
    logic [7:0] wq[$];
    logic [8:0] cq[$];

    ws_loop_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .nw(nw), .tn(tn), .tk(tk), .tm(tm),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .stall(stall),
        .wctrl(wctrl), .weight(weight), .ctrl(ctrl), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // scoreboard: every weight strobe and every nonzero control word must match the queue head
    always @(negedge clk) begin
        if (wctrl === 1'b1) begin
            wc_cnt++;
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL weight_sb unexpected strobe weight=%0h", weight);
            end else begin
                logic [7:0] ew;
                ew = wq.pop_front();
                if (weight !== ew) begin
                    failures++;
                    $display("FAIL weight_sb got=%0h exp=%0h", weight, ew);
                end
            end
        end
        if (!$isunknown(ctrl) && ctrl != '0) begin
            if (ctrl[3]) fin_cyc = cyc;
            checks++;
            if (cq.size() == 0) begin
                failures++;
                $display("FAIL ctrl_sb unexpected ctrl=%03h", ctrl);
            end else begin
                logic [8:0] ec;
                ec = cq.pop_front();
                if (ctrl !== ec) begin
                    failures++;
                    $display("FAIL ctrl_sb got=%03h exp=%03h", ctrl, ec);
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int a, input int b, input int c, input int d);
        nw = 10'(a); tn = 10'(b); tk = 10'(c); tm = 10'(d);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int count, input bit toggle);
        int sent = 0;
        int n = 0;
        bit v = 1'b1;
        bit hs;
        while (sent < count && n < 100) begin
            w_valid = toggle ? v : 1'b1;
            w_data = 8'(sent + 1);
            @(negedge clk);
            hs = w_valid && w_ready;
            tick();
            if (hs) sent++;
            v = !v;
            n++;
        end
        w_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; w_valid = 0; w_data = 0; stall = 0;
        nw = 0; tn = 0; tk = 0; tm = 0;
        repeat (2) tick();
        checks++;
        if ({ctrl, wctrl, weight, w_ready, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {ctrl, wctrl, weight, w_ready, busy, done});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b done=%b exp=0,0", busy, done);
        end
    endtask

    task automatic test_load_run();
        int d0 = done_cnt;
        int w0 = wc_cnt;
        for (int i = 1; i <= 4; i++) wq.push_back(8'(i));
        cq.push_back(9'h001); cq.push_back(9'h009);
        do_start(4, 2, 1, 1);
        checks++;
        if (busy !== 1'b1 || w_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_enter busy=%b w_ready=%b exp=1,1", busy, w_ready);
        end
        feed(4, 1'b0);
        repeat (8) tick();
        checks++;
        if (wc_cnt - w0 != 4) begin
            failures++;
            $display("FAIL load_strobes got=%0d exp=4", wc_cnt - w0);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != fin_cyc + 1) begin
            failures++;
            $display("FAIL load_done count=%0d exp=1 lag=%0d exp=1", done_cnt - d0, done_cyc - fin_cyc);
        end
        checks++;
        if (wq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL load_queues wq=%0d cq=%0d exp=0,0", wq.size(), cq.size());
        end
    endtask

    task automatic test_nested();
        int d0 = done_cnt;
        logic [8:0] seq [12] = '{9'h001, 9'h001, 9'h081, 9'h001, 9'h001, 9'h021,
                                 9'h001, 9'h001, 9'h081, 9'h001, 9'h001, 9'h009};
        foreach (seq[i]) cq.push_back(seq[i]);
        do_start(0, 3, 2, 2);
        repeat (16) tick();
        checks++;
        if (cq.size() != 0) begin
            failures++;
            $display("FAIL nested_words left=%0d exp=0", cq.size());
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != fin_cyc + 1) begin
            failures++;
            $display("FAIL nested_done count=%0d exp=1 lag=%0d exp=1", done_cnt - d0, done_cyc - fin_cyc);
        end
    endtask

    task automatic test_toggle_load();
        int w0 = wc_cnt;
        for (int i = 1; i <= 3; i++) wq.push_back(8'(i));
        cq.push_back(9'h009);
        do_start(3, 1, 1, 1);
        feed(3, 1'b1);
        checks++;
        if (w_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL toggle_run_entry w_ready=%b busy=%b exp=0,1", w_ready, busy);
        end
        repeat (5) tick();
        checks++;
        if (wc_cnt - w0 != 3 || wq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL toggle_strobes got=%0d exp=3 wq=%0d cq=%0d", wc_cnt - w0, wq.size(), cq.size());
        end
    endtask

    task automatic test_stall();
        logic [8:0] exp [7] = '{9'h001, 9'h001, 9'h000, 9'h000, 9'h001, 9'h009, 9'h000};
        cq.push_back(9'h001); cq.push_back(9'h001); cq.push_back(9'h001); cq.push_back(9'h009);
        do_start(0, 4, 1, 1);
        for (int i = 0; i < 7; i++) begin
            stall = (i == 2 || i == 3);
            tick();
            @(negedge clk);
            checks++;
            if (ctrl !== exp[i]) begin
                failures++;
                $display("FAIL stall_ctrl[%0d] got=%03h exp=%03h", i, ctrl, exp[i]);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (cq.size() != 0) begin
            failures++;
            $display("FAIL stall_words left=%0d exp=0", cq.size());
        end
    endtask

    task automatic test_zero_bound();
        bit exp_done [3] = '{1'b0, 1'b1, 1'b0};
        do_start(2, 3, 3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== exp_done[i] || busy !== 1'b0 || w_ready !== 1'b0 || ctrl !== '0) begin
                failures++;
                $display("FAIL zero_bound[%0d] done=%b exp=%b busy=%b w_ready=%b ctrl=%03h", i, done, exp_done[i], busy, w_ready, ctrl);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        cq.push_back(9'h001); cq.push_back(9'h001);
        do_start(0, 8, 1, 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ctrl !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid ctrl=%03h busy=%b exp=0,0", ctrl, busy);
        end
        repeat (12) tick();
        checks++;
        if (done_cnt != d0 || cq.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet dones=%0d exp=0 left=%0d", done_cnt - d0, cq.size());
        end
        wq.push_back(8'h01);
        cq.push_back(9'h001); cq.push_back(9'h081); cq.push_back(9'h001); cq.push_back(9'h009);
        do_start(1, 2, 2, 1);
        feed(1, 1'b0);
        repeat (8) tick();
        checks++;
        if (done_cnt - d0 != 1 || wq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_restart dones=%0d exp=1 wq=%0d cq=%0d", done_cnt - d0, wq.size(), cq.size());
        end
    endtask

    task automatic test_max_bound();
        int d0 = done_cnt;
        for (int i = 0; i < 1022; i++) cq.push_back(9'h001);
        cq.push_back(9'h009);
        do_start(0, 1023, 1, 1);
        repeat (3) tick();
        do_start(0, 1, 1, 1);
        repeat (1030) tick();
        checks++;
        if (done_cnt - d0 != 1 || cq.size() != 0 || done_cyc != fin_cyc + 1) begin
            failures++;
            $display("FAIL max_bound dones=%0d exp=1 left=%0d exp=0", done_cnt - d0, cq.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_nested();
        test_toggle_load();
        test_stall();
        test_zero_bound();
        test_reset_mid();
        test_max_bound();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ws_loop_ctrl.md
WS_LOOP_CTRL -- requirements
Module: ws_loop_ctrl

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 8, weight data width.
REQ-002 SHALL have parameter CTRL_WIDTH, default 9, PE control word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 10, width of every loop bound and counter.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have start  input  1  single-cycle request to begin load+run; honoured only in IDLE.
REQ-007 SHALL have nw  input  CNT_WIDTH  number of weights to load; sampled on accepted start.
REQ-008 SHALL have tn, tk, tm  input  CNT_WIDTH each  loop bounds (inner, middle, outer); sampled on accepted start.
REQ-009 SHALL have w_valid  input  1  upstream weight valid.
REQ-010 SHALL have w_data  input  OP_WIDTH  upstream weight data.
REQ-011 SHALL have w_ready  output  1  weight accepted this cycle when w_valid&&w_ready.
REQ-012 SHALL have stall  input  1  freezes RUN-state counters; ctrl forced to zero.
REQ-013 SHALL have wctrl  output  1  registered PE weight write strobe.
REQ-014 SHALL have weight  output  OP_WIDTH  registered PE weight data.
REQ-015 SHALL have ctrl  output  CTRL_WIDTH  registered PE control word.
REQ-016 SHALL have busy  output  1  high in LOAD and RUN.
REQ-017 SHALL have done  output  1  one-cycle pulse at end of RUN.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-019 IDLE: start=1 latches nw/tn/tk/tm; next state LOAD if nw!=0, else RUN; if tn, tk or tm is 0, next state DONE (no LOAD, no RUN cycles).
REQ-020 LOAD: w_ready=1; each handshake increments load counter; on nth handshake (count==nw-1) next state RUN; w_ready=0 in all other states.
REQ-021 wctrl SHALL equal w_valid&&w_ready of the previous cycle; weight SHALL equal w_data of the previous handshake, held otherwise.
REQ-022 RUN: counters n (inner), k, m SHALL iterate n 0..tn-1, then k 0..tk-1, then m 0..tm-1; exactly tn*tk*tm non-stalled RUN cycles.
REQ-023 Per non-stalled RUN cycle, registered ctrl (valid next cycle) SHALL be: bit0=1 always.
REQ-024 bit7=1 iff n==tn-1 and k!=tk-1.
REQ-025 bit5=1 iff n==tn-1, k==tk-1 and m!=tm-1.
REQ-026 bit3=1 iff n==tn-1, k==tk-1, m==tm-1 (final cycle); bits 7 and 5 SHALL be 0 then.
REQ-027 All other ctrl bits SHALL be 0; bits 7/5/3 SHALL be mutually exclusive.
REQ-028 stall=1 in RUN: counters hold, ctrl next cycle=0; stall ignored outside RUN.
REQ-029 After final RUN cycle, next state DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-030 start outside IDLE SHALL be ignored; bounds SHALL NOT change mid-operation.
REQ-031 Counters SHALL NOT wrap; tn=tk=tm=2^CNT_WIDTH-1 SHALL run exactly their product of cycles.
REQ-032 busy SHALL be registered, asserted the cycle after accepted start, deasserted in DONE.

Reset
REQ-033 rst=1 SHALL force state IDLE, all counters 0, ctrl=0, wctrl=0, weight=0, w_ready=0, busy=0, done=0 on next edge.
REQ-034 rst mid-LOAD or mid-RUN SHALL abandon the operation with no done pulse and no further ctrl/wctrl activity.
REQ-035 rst SHALL take priority over start, stall and handshakes in the same cycle.

Verification
REQ-036 nw=4, tn=2,tk=1,tm=1, w_valid continuous data 1..4 -> wctrl high 4 cycles with weight 1,2,3,4; then ctrl 0x001, 0x009; done one cycle later.
REQ-037 nw=0, tn=3,tk=2,tm=2 -> ctrl sequence 001,001,081,001,001,021,001,001,081,001,001,009 (hex, 12 cycles); one done pulse.
REQ-038 nw=3 with w_valid toggling 1,0,1,0,1 -> exactly 3 wctrl pulses, RUN entered after third handshake.
REQ-039 tn=4,tk=1,tm=1 with stall high for 2 cycles after 2nd RUN cycle -> ctrl 001,001,000,000,001,009; total 4 nonzero words.
REQ-040 tm=0 with start -> busy never set, done pulses 2 cycles after start, ctrl stays 0.
REQ-041 rst asserted on 3rd RUN cycle of tn=8 run -> ctrl=0, busy=0 next cycle, no done; fresh start afterwards runs normally.
